fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have parameter RA_W, default 5, giving the register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-005 The block SHALL have ports id_rs and id_rt, input, RA_W each, the source registers of the instruction in ID.
REQ-006 The block SHALL have ports id_use_rs and id_use_rt, input, 1 each, set when the ID instruction reads rs or rt.
REQ-007 The block SHALL have port id_dst, input, RA_W, the destination register of the ID instruction.
REQ-008 The block SHALL have ports id_regwrite and id_memread, input, 1 each, set when the ID instruction writes a register or is a load.
REQ-009 The block SHALL have port hold, input, 1, the global freeze (memory busy).
REQ-010 The block SHALL have port flush, input, 1, the branch/jump taken signal resolved in EX.
REQ-011 The block SHALL have ports fwd_a and fwd_b, output, 2 each, the selects for the EX operand 3:1 muxes: 00 register file, 01 WB result, 10 MEM result; 11 never driven.
REQ-012 The block SHALL have port stall, output, 1, the load-use hazard flag.
REQ-013 The block SHALL have ports pc_en and ifid_en, output, 1 each, the write enables for the PC and IF/ID registers.
REQ-014 The block SHALL have port stall_cnt, output, CNT_W, the count of load-use stall cycles.

Function
REQ-015 The block SHALL hold shadow stages: EX {rs, rt, dst, regwrite, memread}, MEM {dst, regwrite}, WB {dst, regwrite}.
REQ-016 On an advance (hold=0), the stages SHALL shift in the order ID->EX->MEM->WB in one cycle.
REQ-017 If stall=1 or flush=1 during an advance, the EX stage SHALL load a bubble (all fields 0), while MEM and WB still shift.
REQ-018 When hold=1, all stage registers and stall_cnt SHALL keep their values.
REQ-019 fwd_a SHALL be 10 when MEM.regwrite and MEM.dst!=0 and MEM.dst==EX.rs; otherwise 01 when WB.regwrite and WB.dst!=0 and WB.dst==EX.rs; otherwise 00.
REQ-020 fwd_b SHALL follow the same rule as fwd_a using EX.rt; MEM priority over WB is mandatory.
REQ-021 fwd_a and fwd_b SHALL be combinational from the stage registers, valid in the same cycle with zero latency.
REQ-022 stall SHALL be 1 exactly when flush=0 and EX.memread and EX.dst!=0 and the ID instruction reads EX.dst (id_use_rs with id_rs==EX.dst, or id_use_rt with id_rt==EX.dst).
REQ-023 pc_en and ifid_en SHALL each equal ~(stall | hold).
REQ-024 When flush and a load-use condition coincide, flush SHALL win: stall=0, pc_en=ifid_en=1 unless hold=1, and EX loads a bubble.
REQ-025 stall_cnt SHALL increment by 1 on each edge with stall=1 and hold=0, and SHALL saturate at all-ones without wrapping.
REQ-026 Register 0 SHALL never be a forwarding or stall source, regardless of the regwrite or memread flags.
REQ-027 A stall SHALL last exactly one cycle per load-use pair, because the bubble clears EX.memread.

Reset
REQ-028 On rst=1 at a clock edge, all stage fields and stall_cnt SHALL become 0, with rst taking priority over hold and flush.
REQ-029 In the cycle after reset, the outputs SHALL be fwd_a=fwd_b=00, stall=0, pc_en=ifid_en=1, stall_cnt=0.
REQ-030 A reset asserted mid-stall SHALL clear the stall on the following edge, and the pending load SHALL be discarded.

Verification
REQ-031 The bench SHALL drive "ID: add dst=3 regwrite", then "ID: sub rs=3" the next cycle; the required response is fwd_a=10 during sub in EX.
REQ-032 The bench SHALL drive dst=3 writer, one unrelated instruction, then a reader with rt=3; the required response is fwd_b=01.
REQ-033 The bench SHALL have consecutive writers to register 5 followed by a reader with rs=5; the required response is fwd_a=10 (the newest value wins).
REQ-034 The bench SHALL drive a load with dst=7, then a reader with rs=7; the required response is stall=1 and pc_en=ifid_en=0 for one cycle, stall_cnt goes 0->1, then fwd_a=01 (the load is in WB when the reader reaches EX).
REQ-035 The bench SHALL drive a load with dst=7 and a reader with rs=7 while flush=1; the required response is stall=0 and the EX bubble gives fwd_a=00 on the next cycle.
REQ-036 The bench SHALL hold hold=1 for 3 cycles during a load-use stall; the required response is unchanged fwd, stall and stall_cnt, then release resumes normally; a writer with dst=0 SHALL never produce a non-00 select.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding selects and load-use stall detection for a classic 5-stage pipeline.
// Keeps a shadow copy of the EX/MEM/WB register fields needed to resolve data hazards.
module fwd_hazard_unit #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0]       FWD_RF  = 2'b00;
  localparam logic [1:0]       FWD_WB  = 2'b01;
  localparam logic [1:0]       FWD_MEM = 2'b10;
  localparam logic [RA_W-1:0]  REG_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [RA_W-1:0]  ex_rs_q, ex_rs_d;
  logic [RA_W-1:0]  ex_rt_q, ex_rt_d;
  logic [RA_W-1:0]  ex_dst_q, ex_dst_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic             ex_memread_q, ex_memread_d;
  logic [RA_W-1:0]  mem_dst_q, mem_dst_d;
  logic             mem_regwrite_q, mem_regwrite_d;
  logic [RA_W-1:0]  wb_dst_q, wb_dst_d;
  logic             wb_regwrite_q, wb_regwrite_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_wr_valid;
  logic wb_wr_valid;
  logic load_in_ex;
  logic id_reads_load;
  logic bubble_ex;

  // Register 0 is hard-wired, so a write to it is never a hazard source.
  always_comb begin
    mem_wr_valid = mem_regwrite_q && (mem_dst_q != REG_ZERO);
    wb_wr_valid  = wb_regwrite_q && (wb_dst_q != REG_ZERO);
    load_in_ex   = ex_memread_q && (ex_dst_q != REG_ZERO);
  end

  // MEM holds the younger result, so it is checked before WB.
  always_comb begin
    fwd_a = FWD_RF;
    if (mem_wr_valid && (mem_dst_q == ex_rs_q)) begin
      fwd_a = FWD_MEM;
    end else if (wb_wr_valid && (wb_dst_q == ex_rs_q)) begin
      fwd_a = FWD_WB;
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (mem_wr_valid && (mem_dst_q == ex_rt_q)) begin
      fwd_b = FWD_MEM;
    end else if (wb_wr_valid && (wb_dst_q == ex_rt_q)) begin
      fwd_b = FWD_WB;
    end
  end

  // A taken branch squashes the ID instruction, so it cannot cause a stall.
  always_comb begin
    id_reads_load = (id_use_rs && (id_rs == ex_dst_q)) ||
                    (id_use_rt && (id_rt == ex_dst_q));
    stall     = !flush && load_in_ex && id_reads_load;
    pc_en     = !(stall || hold);
    ifid_en   = !(stall || hold);
    bubble_ex = stall || flush;
  end

  always_comb begin
    ex_rs_d        = ex_rs_q;
    ex_rt_d        = ex_rt_q;
    ex_dst_d       = ex_dst_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    mem_dst_d      = mem_dst_q;
    mem_regwrite_d = mem_regwrite_q;
    wb_dst_d       = wb_dst_q;
    wb_regwrite_d  = wb_regwrite_q;
    stall_cnt_d    = stall_cnt_q;

    if (!hold) begin
      wb_dst_d       = mem_dst_q;
      wb_regwrite_d  = mem_regwrite_q;
      mem_dst_d      = ex_dst_q;
      mem_regwrite_d = ex_regwrite_q;
      if (bubble_ex) begin
        ex_rs_d       = '0;
        ex_rt_d       = '0;
        ex_dst_d      = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
      end else begin
        ex_rs_d       = id_rs;
        ex_rt_d       = id_rt;
        ex_dst_d      = id_dst;
        ex_regwrite_d = id_regwrite;
        ex_memread_d  = id_memread;
      end
      if (stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dst_q       <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_dst_q      <= '0;
      mem_regwrite_q <= 1'b0;
      wb_dst_q       <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dst_q       <= ex_dst_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_dst_q      <= mem_dst_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_dst_q       <= wb_dst_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed hazard scenarios followed by random traffic,
// checked against an instruction-level pipeline model kept in a queue.
module tb_fwd_hazard_unit;

  localparam int RA_W  = 5;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] dst;
    logic            regwrite;
    logic            memread;
  } instr_t;

  typedef struct {
    instr_t id;
    logic   use_rs;
    logic   use_rt;
    logic   hold;
    logic   flush;
    logic   rst;
  } stim_t;

  typedef struct {
    int fwd_a;
    int fwd_b;
    int stall;
    int pc_en;
    int ifid_en;
    int cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [RA_W-1:0]  id_rs, id_rt, id_dst;
  logic             id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic             hold, flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall, pc_en, ifid_en;
  logic [CNT_W-1:0] stall_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  exp_t   exp_q[$];
  instr_t pipe[$];
  int     model_cnt;

  fwd_hazard_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .hold(hold), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Pipeline model: pipe[0] is the instruction in EX, pipe[1] in MEM, pipe[2] in WB.
  function automatic instr_t bubble();
    instr_t b;
    b.rs = '0; b.rt = '0; b.dst = '0; b.regwrite = 1'b0; b.memread = 1'b0;
    return b;
  endfunction

  function automatic void resetModel();
    pipe.delete();
    for (int k = 0; k < 3; k++) pipe.push_back(bubble());
    model_cnt = 0;
  endfunction

  // Newest in-flight producer of register r wins; r0 is never forwarded.
  function automatic int fwdFor(logic [RA_W-1:0] r);
    if (r == 0) return 0;
    if (pipe[1].regwrite && pipe[1].dst == r) return 2;
    if (pipe[2].regwrite && pipe[2].dst == r) return 1;
    return 0;
  endfunction

  function automatic bit loadUse(stim_t s);
    bit reads;
    if (s.flush || !pipe[0].memread || pipe[0].dst == 0) return 1'b0;
    reads = (s.use_rs && s.id.rs == pipe[0].dst) || (s.use_rt && s.id.rt == pipe[0].dst);
    return reads;
  endfunction

  function automatic stim_t mk(int rs, int rt, bit urs, bit urt, int dst, bit rw, bit mr,
                               bit h = 1'b0, bit f = 1'b0, bit r = 1'b0);
    stim_t s;
    s.id.rs = RA_W'(rs); s.id.rt = RA_W'(rt); s.id.dst = RA_W'(dst);
    s.id.regwrite = rw; s.id.memread = mr;
    s.use_rs = urs; s.use_rt = urt; s.hold = h; s.flush = f; s.rst = r;
    return s;
  endfunction

  // Drives one cycle of ID/control inputs, queues the expected response, then advances the model.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   st;
    id_rs = s.id.rs; id_rt = s.id.rt; id_dst = s.id.dst;
    id_regwrite = s.id.regwrite; id_memread = s.id.memread;
    id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    hold = s.hold; flush = s.flush; rst = s.rst;
    st = loadUse(s);
    e.fwd_a   = fwdFor(pipe[0].rs);
    e.fwd_b   = fwdFor(pipe[0].rt);
    e.stall   = st;
    e.pc_en   = !(st || s.hold);
    e.ifid_en = !(st || s.hold);
    e.cnt     = model_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      resetModel();
    end else if (!s.hold) begin
      void'(pipe.pop_back());
      pipe.push_front((st || s.flush) ? bubble() : s.id);
      if (st && model_cnt < CNT_MAX) model_cnt++;
    end
    #1;
  endtask

  task automatic compare(input string name, input int act, input int req);
    checks_total++;
    if (act == req) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic checkOutput(input exp_t e);
    compare("fwd_a", int'(fwd_a), e.fwd_a);
    compare("fwd_b", int'(fwd_b), e.fwd_b);
    compare("stall", int'(stall), e.stall);
    compare("pc_en", int'(pc_en), e.pc_en);
    compare("ifid_en", int'(ifid_en), e.ifid_en);
    compare("stall_cnt", int'(stall_cnt), e.cnt);
  endtask

  // Every cycle is an output beat; sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    stim_t nop, s;
    nop = mk(0, 0, 0, 0, 0, 0, 0);
    id_rs = '0; id_rt = '0; id_dst = '0; id_use_rs = 0; id_use_rt = 0;
    id_regwrite = 0; id_memread = 0; hold = 0; flush = 0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetModel();

    $display("[TB] post-reset state");
    applyStimulus(nop);

    $display("[TB] EX/MEM forwarding");
    applyStimulus(mk(1, 2, 1, 1, 3, 1, 0));
    applyStimulus(mk(3, 4, 1, 1, 8, 1, 0));
    applyStimulus(nop);

    $display("[TB] MEM/WB forwarding on rt");
    applyStimulus(mk(1, 2, 1, 1, 3, 1, 0));
    applyStimulus(mk(9, 10, 1, 1, 11, 1, 0));
    applyStimulus(mk(12, 3, 1, 1, 13, 1, 0));
    applyStimulus(nop);

    $display("[TB] back-to-back writers");
    applyStimulus(mk(1, 2, 1, 1, 5, 1, 0));
    applyStimulus(mk(6, 2, 1, 1, 5, 1, 0));
    applyStimulus(mk(5, 9, 1, 1, 14, 1, 0));
    applyStimulus(nop);

    $display("[TB] load-use stall");
    applyStimulus(mk(1, 0, 1, 0, 7, 1, 1));
    applyStimulus(mk(7, 0, 1, 0, 15, 1, 0));
    applyStimulus(mk(7, 0, 1, 0, 15, 1, 0));
    applyStimulus(nop);
    applyStimulus(nop);

    $display("[TB] flush overrides load-use");
    applyStimulus(mk(1, 0, 1, 0, 7, 1, 1));
    applyStimulus(mk(7, 0, 1, 0, 15, 1, 0, 0, 1));
    applyStimulus(nop);

    $display("[TB] hold during stall");
    applyStimulus(mk(1, 0, 1, 0, 7, 1, 1));
    repeat (3) applyStimulus(mk(7, 0, 1, 0, 15, 1, 0, 1));
    applyStimulus(mk(7, 0, 1, 0, 15, 1, 0));
    applyStimulus(mk(7, 0, 1, 0, 15, 1, 0));
    applyStimulus(nop);

    $display("[TB] register 0 writer and load");
    applyStimulus(mk(1, 2, 1, 1, 0, 1, 1));
    applyStimulus(mk(0, 0, 1, 1, 4, 1, 0));
    applyStimulus(mk(0, 0, 1, 1, 4, 1, 0));
    applyStimulus(nop);

    $display("[TB] reset mid-stall");
    applyStimulus(mk(1, 0, 1, 0, 7, 1, 1));
    applyStimulus(mk(7, 0, 1, 0, 15, 1, 0, 1, 1, 1));
    applyStimulus(mk(7, 0, 1, 0, 15, 1, 0));
    applyStimulus(nop);

    $display("[TB] stall counter saturation");
    repeat (10) begin
      applyStimulus(mk(2, 0, 1, 0, 9, 1, 1));
      applyStimulus(mk(0, 9, 0, 1, 10, 1, 0));
      applyStimulus(mk(0, 9, 0, 1, 10, 1, 0));
    end
    applyStimulus(nop);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      s = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
      applyStimulus(s);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks_total++;
      $display("[TB] FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    #2;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
